picc_tx_scheduler: RTL and testbench

PICC_TX_SCHEDULER -- requirements
Module: picc_tx_scheduler

---
 rtl/picc_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/picc_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_picc_tx_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picc_pkg.sv
// Shared types and constants for the PICC transmit scheduler.
package picc_pkg;

    localparam int unsigned PAYLOAD_W  = 40;
    localparam int unsigned NBYTES_W   = 3;
    localparam int unsigned MAX_NBYTES = 5;

    typedef enum logic [1:0] {
        IDLE,
        FDT_WAIT,
        TRIG,
        WAIT_DONE
    } picc_state_e;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] data;
        logic [NBYTES_W-1:0]  nbytes;
    } picc_frame_t;

    // A frame is transmittable only with 1..MAX_NBYTES payload bytes.
    function automatic logic nbytes_ok(input logic [NBYTES_W-1:0] n);
        return (n != '0) && (n <= NBYTES_W'(MAX_NBYTES));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant, search starts at the index after the last accepted winner.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant_c
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] next_ptr_c;
    logic             found_c;
    int unsigned      idx;

    always_comb begin
        grant_c    = '0;
        next_ptr_c = ptr;
        found_c    = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found_c && req[IDX_W'(idx)]) begin
                found_c             = 1'b1;
                grant_c[IDX_W'(idx)] = 1'b1;
                next_ptr_c          = (idx + 1 == N) ? '0 : IDX_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr <= '0;
        end else if (accept && found_c) begin
            ptr <= next_ptr_c;
        end
    end

endmodule

// File: rtl/picc_tx_scheduler.sv
// PICC response scheduler: round-robin grant, frame-delay hold-off, trigger and done handshake.
// Optional WAIT_DONE watchdog is built when PICC_SCHED_TIMEOUT_EN is defined.
module picc_tx_scheduler
    import picc_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned FDT_CYCLES     = 11720,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]  req_data_in,
    input  logic [NUM_REQ*NBYTES_W-1:0]   req_nbytes_in,
    output logic [NUM_REQ-1:0]            grant_out,
    input  logic                          rx_end_in,
    output logic [PAYLOAD_W-1:0]          picc_data_out,
    output logic [NBYTES_W-1:0]           picc_num_bytes_out,
    output logic                          picc_trigger_out,
    input  logic                          picc_done_in,
    output logic                          busy_out,
    output logic                          drop_out,
    output logic                          timeout_out,
    output logic [7:0]                    tx_count_out
);

    localparam int unsigned FDT_W = (FDT_CYCLES > 0) ? $clog2(FDT_CYCLES + 1) : 1;

    picc_state_e          state;
    logic [FDT_W-1:0]     fdt_cnt;
    logic                 done_q;
    picc_frame_t          frame_q;
    picc_frame_t          sel_frame_c;
    logic [NUM_REQ-1:0]   grant_c;
    logic                 take_c;
    logic                 done_rise_c;
    logic                 wd_hit_c;

    assign take_c      = (state == IDLE) && (|req_in);
    assign done_rise_c = picc_done_in && !done_q;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .req     (req_in),
        .accept  (take_c),
        .grant_c (grant_c)
    );

    always_comb begin
        sel_frame_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_frame_c.data   = req_data_in[i*PAYLOAD_W +: PAYLOAD_W];
                sel_frame_c.nbytes = req_nbytes_in[i*NBYTES_W +: NBYTES_W];
            end
        end
    end

    // Frame delay time counts from the end of the PCD frame, so it also runs while IDLE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fdt_cnt <= '0;
        end else if (rx_end_in && (state == IDLE || state == FDT_WAIT)) begin
            fdt_cnt <= FDT_W'(FDT_CYCLES);
        end else if (fdt_cnt != '0) begin
            fdt_cnt <= fdt_cnt - FDT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            done_q <= 1'b0;
        end else begin
            done_q <= picc_done_in;
        end
    end

`ifdef PICC_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wd_cnt <= '0;
        end else if (state != WAIT_DONE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_hit_c = (state == WAIT_DONE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: WAIT_DONE waits for the done edge indefinitely.
    assign wd_hit_c = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            grant_out          <= '0;
            drop_out           <= 1'b0;
            picc_trigger_out   <= 1'b0;
            timeout_out        <= 1'b0;
            busy_out           <= 1'b0;
            frame_q            <= '0;
            picc_data_out      <= '0;
            picc_num_bytes_out <= '0;
            tx_count_out       <= '0;
        end else begin
            grant_out        <= '0;
            drop_out         <= 1'b0;
            picc_trigger_out <= 1'b0;
            timeout_out      <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_c) begin
                        grant_out <= grant_c;
                        frame_q   <= sel_frame_c;
                        if (nbytes_ok(sel_frame_c.nbytes)) begin
                            state    <= FDT_WAIT;
                            busy_out <= 1'b1;
                        end else begin
                            drop_out <= 1'b1;
                        end
                    end
                end
                FDT_WAIT: begin
                    if (fdt_cnt == '0) begin
                        state              <= TRIG;
                        picc_trigger_out   <= 1'b1;
                        picc_data_out      <= frame_q.data;
                        picc_num_bytes_out <= frame_q.nbytes;
                    end
                end
                TRIG: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_rise_c) begin
                        tx_count_out <= tx_count_out + 8'd1;
                        state        <= IDLE;
                        busy_out     <= 1'b0;
                    end else if (wd_hit_c) begin
                        timeout_out <= 1'b1;
                        state       <= IDLE;
                        busy_out    <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picc_tx_scheduler.sv
// Scoreboard bench for picc_tx_scheduler: grants, triggers and completions against a round-robin/FDT model.
// The watchdog case runs only when PICC_SCHED_TIMEOUT_EN is defined.
module tb_picc_tx_scheduler;

    localparam int unsigned N   = 3;
    localparam int unsigned FDT = 8;
    localparam int unsigned TMO = 100;
    localparam int unsigned PW  = 40;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [N-1:0]      req_in;
    logic [N*PW-1:0]   req_data_in;
    logic [N*3-1:0]    req_nbytes_in;
    logic [N-1:0]      grant_out;
    logic              rx_end_in;
    logic [PW-1:0]     picc_data_out;
    logic [2:0]        picc_num_bytes_out;
    logic              picc_trigger_out;
    logic              picc_done_in;
    logic              busy_out;
    logic              drop_out;
    logic              timeout_out;
    logic [7:0]        tx_count_out;

    picc_tx_scheduler #(
        .NUM_REQ        (N),
        .FDT_CYCLES     (FDT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .req_in             (req_in),
        .req_data_in        (req_data_in),
        .req_nbytes_in      (req_nbytes_in),
        .grant_out          (grant_out),
        .rx_end_in          (rx_end_in),
        .picc_data_out      (picc_data_out),
        .picc_num_bytes_out (picc_num_bytes_out),
        .picc_trigger_out   (picc_trigger_out),
        .picc_done_in       (picc_done_in),
        .busy_out           (busy_out),
        .drop_out           (drop_out),
        .timeout_out        (timeout_out),
        .tx_count_out       (tx_count_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int rr_ptr   = 0;
    int tx_model = 0;

    typedef struct { logic [2:0] grant; logic drop; int cyc; } grant_exp_t;
    typedef struct { logic [39:0] data; logic [2:0] nb; int cyc; } trig_exp_t;
    typedef struct { logic [7:0] cnt; int cyc; } cnt_exp_t;

    grant_exp_t gq[$];
    trig_exp_t  tq[$];
    cnt_exp_t   cq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] rand40();
        return {8'($urandom()), 32'($urandom())};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a grant, trigger or count change
    logic [7:0] prev_cnt = 8'd0;
    always @(negedge clk_in) begin
        grant_exp_t ge;
        trig_exp_t  te;
        cnt_exp_t   ce;
        if (rst_in) begin
            prev_cnt = 8'd0;
        end else begin
            if (grant_out != '0 || drop_out) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 64'({grant_out, drop_out}), 64'd0);
                end else begin
                    ge = gq.pop_front();
                    chk("grant", 64'(grant_out), 64'(ge.grant));
                    chk("drop", 64'(drop_out), 64'(ge.drop));
                    chk("grant_cycle", 64'(cyc), 64'(ge.cyc));
                end
            end
            if (picc_trigger_out) begin
                if (tq.size() == 0) begin
                    chk("trigger_unexpected", 64'(picc_trigger_out), 64'd0);
                end else begin
                    te = tq.pop_front();
                    chk("trig_data", 64'(picc_data_out), 64'(te.data));
                    chk("trig_nbytes", 64'(picc_num_bytes_out), 64'(te.nb));
                    chk("trig_cycle", 64'(cyc), 64'(te.cyc));
                end
            end
            if (tx_count_out !== prev_cnt) begin
                if (cq.size() == 0) begin
                    chk("count_unexpected", 64'(tx_count_out), 64'(prev_cnt));
                end else begin
                    ce = cq.pop_front();
                    chk("tx_count", 64'(tx_count_out), 64'(ce.cnt));
                    chk("tx_count_cycle", 64'(cyc), 64'(ce.cyc));
                end
                prev_cnt = tx_count_out;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 64'(grant_out), 64'd0);
        chk({tag, "_trigger"}, 64'(picc_trigger_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy_out), 64'd0);
        chk({tag, "_drop"}, 64'(drop_out), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout_out), 64'd0);
        chk({tag, "_data"}, 64'(picc_data_out), 64'd0);
        chk({tag, "_nbytes"}, 64'(picc_num_bytes_out), 64'd0);
        chk({tag, "_count"}, 64'(tx_count_out), 64'd0);
    endtask

    // mode 0: done pulse after WAIT_DONE entry; 1: done stuck high from the request; 2: no done
    task automatic txn(input logic [2:0] req, input logic [39:0] d, input logic [2:0] nb,
                       input bit rx, input int mode, output int trig_cyc);
        int w;
        int t0;
        int guard;
        int dly;
        bit drop;
        grant_exp_t ge;
        trig_exp_t te;
        cnt_exp_t ce;
        trig_cyc = -1;
        guard = 0;
        @(posedge clk_in); #1;
        while (busy_out && guard < 500) begin
            @(posedge clk_in); #1;
            guard++;
        end
        if (busy_out) chk("idle_before_req", 64'(busy_out), 64'd0);

        w = -1;
        for (int k = 0; k < int'(N); k++) begin
            int idx;
            idx = (rr_ptr + k) % int'(N);
            if (w < 0 && req[idx]) w = idx;
        end
        drop = (nb == 3'd0) || (nb > 3'd5);
        for (int i = 0; i < int'(N); i++) begin
            req_data_in[i*PW +: PW] = (i == w) ? d : rand40();
            req_nbytes_in[i*3 +: 3] = (i == w) ? nb : 3'($urandom_range(0, 7));
        end
        req_in    = req;
        rx_end_in = rx && !drop;
        if (mode == 1) picc_done_in = 1'b1;
        t0 = cyc;
        ge.grant = 3'(1 << w);
        ge.drop  = drop;
        ge.cyc   = t0 + 1;
        gq.push_back(ge);
        rr_ptr = (w + 1) % int'(N);

        @(posedge clk_in); #1;
        req_in    = '0;
        rx_end_in = 1'b0;
        if (drop) begin
            picc_done_in = 1'b0;
            return;
        end

        trig_cyc = t0 + 1 + (rx ? int'(FDT) + 1 : 1);
        te = '{d, nb, trig_cyc};
        tq.push_back(te);
        while (cyc < trig_cyc + 2) begin
            @(posedge clk_in); #1;
        end
        if (mode == 2) return;

        if (mode == 1) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk_in); #1;
            end
            chk("stuck_done_busy", 64'(busy_out), 64'd1);
            chk("hold_data", 64'(picc_data_out), 64'(d));
            chk("hold_nbytes", 64'(picc_num_bytes_out), 64'(nb));
            picc_done_in = 1'b0;
            @(posedge clk_in); #1;
        end else begin
            dly = $urandom_range(0, 4);
            for (int k = 0; k < dly; k++) begin
                @(posedge clk_in); #1;
            end
        end

        picc_done_in = 1'b1;
        tx_model = (tx_model + 1) % 256;
        ce.cnt = 8'(tx_model);
        ce.cyc = cyc + 1;
        cq.push_back(ce);
        @(posedge clk_in); #1;
        picc_done_in = 1'b0;
        @(posedge clk_in); #1;
        chk("busy_after_done", 64'(busy_out), 64'd0);
    endtask

    initial begin
        repeat (60000) @(posedge clk_in);
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int tc;
        rst_in        = 1'b1;
        req_in        = '0;
        req_data_in   = '0;
        req_nbytes_in = '0;
        rx_end_in     = 1'b0;
        picc_done_in  = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        check_reset_outputs("por");
        @(posedge clk_in); #3;
        rst_in = 1'b0;

        // All three requesters held: rotation from index 0
        for (int k = 0; k < 3; k++) txn(3'b111, rand40(), 3'(k + 1), 1'b0, 0, tc);

        txn(3'b001, 40'h0024906735, 3'd4, 1'b1, 0, tc);

        txn(3'b010, rand40(), 3'd0, 1'b0, 0, tc);
        txn(3'b100, rand40(), 3'd6, 1'b1, 0, tc);
        @(posedge clk_in); #1;
        chk("count_after_drops", 64'(tx_count_out), 64'(tx_model));
        chk("busy_after_drops", 64'(busy_out), 64'd0);

        txn(3'b011, rand40(), 3'd5, 1'b1, 1, tc);

        for (int n = 0; n < 24; n++) begin
            logic [2:0] rq;
            int m;
            rq = 3'($urandom_range(1, 7));
            m  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            txn(rq, rand40(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), m, tc);
        end

`ifdef PICC_SCHED_TIMEOUT_EN
        txn(3'b001, rand40(), 3'd3, 1'b0, 2, tc);
        while (!timeout_out && cyc < tc + int'(TMO) + 200) begin
            @(posedge clk_in); #1;
        end
        chk("timeout_pulse", 64'(timeout_out), 64'd1);
        chk("timeout_cycle", 64'(cyc), 64'(tc + int'(TMO) + 1));
        chk("timeout_busy", 64'(busy_out), 64'd0);
        @(posedge clk_in); #1;
        chk("timeout_one_cycle", 64'(timeout_out), 64'd0);
        chk("timeout_count", 64'(tx_count_out), 64'(tx_model));
`endif

        // Reset while waiting for done: frame abandoned, pointer back to 0
        txn(3'b110, rand40(), 3'd2, 1'b1, 2, tc);
`ifndef PICC_SCHED_TIMEOUT_EN
        for (int k = 0; k < int'(TMO) + 20; k++) begin
            @(posedge clk_in); #1;
        end
        chk("no_watchdog_busy", 64'(busy_out), 64'd1);
        chk("no_watchdog_timeout", 64'(timeout_out), 64'd0);
`endif
        #2;
        rst_in = 1'b1;
        #1;
        check_reset_outputs("midtx");
        rr_ptr   = 0;
        tx_model = 0;
        @(posedge clk_in); #3;
        rst_in = 1'b0;
        txn(3'b111, rand40(), 3'd1, 1'b0, 0, tc);

        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
        end
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("trig_queue_empty", 64'(tq.size()), 64'd0);
        chk("count_queue_empty", 64'(cq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
